// File: rtl/mips_regfile_sb.sv
// MIPS general-purpose register file: two combinational read ports, one byte-enabled
// write port and a per-register busy scoreboard, all updated on the falling clock edge.
module mips_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     read_reg_1,
  input  logic [ADDR_W-1:0]     read_reg_2,
  output logic [DATA_W-1:0]     read_data_1,
  output logic [DATA_W-1:0]     read_data_2,
  output logic                  read_busy_1,
  output logic                  read_busy_2,
  input  logic [ADDR_W-1:0]     write_reg,
  input  logic [DATA_W-1:0]     write_data,
  input  logic [DATA_W/8-1:0]   write_be,
  input  logic                  signal_reg_write,
  input  logic [ADDR_W-1:0]     reserve_reg,
  input  logic                  signal_reserve,
  output logic [ADDR_W:0]       busy_count,
  output logic                  any_busy
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem_word [DEPTH];
  logic [DEPTH-1:0]  busy_reg;
  logic [DEPTH-1:0]  busy_next;
  logic [ADDR_W:0]   busy_count_reg;
  logic [ADDR_W:0]   busy_count_next;
  logic              write_ok;
  logic              reserve_ok;
  logic              zero_1;
  logic              zero_2;

  // Register 0 is silently ignored as a destination when hardwired to zero.
  assign write_ok   = signal_reg_write && !(ZERO_REG && (write_reg == '0));
  assign reserve_ok = signal_reserve && !(ZERO_REG && (reserve_reg == '0));

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      logic [DATA_W-1:0] data_reg;
      logic              write_hit;
      logic              reserve_hit;

      assign write_hit   = write_ok && (write_reg == ADDR_W'(gi));
      assign reserve_hit = reserve_ok && (reserve_reg == ADDR_W'(gi));

      always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg <= '0;
        end else if (write_hit) begin
          for (int b = 0; b < NBYTES; b++) begin
            if (write_be[b]) begin
              data_reg[b*8 +: 8] <= write_data[b*8 +: 8];
            end
          end
        end
      end

      // A reserve on the same edge as the writeback wins: a new producer is outstanding.
      assign busy_next[gi] = reserve_hit ? 1'b1 : (write_hit ? 1'b0 : busy_reg[gi]);
      assign mem_word[gi]  = data_reg;
    end
  endgenerate

  always_comb begin
    busy_count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_count_next = busy_count_next + {{ADDR_W{1'b0}}, busy_next[i]};
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg       <= '0;
      busy_count_reg <= '0;
    end else begin
      busy_reg       <= busy_next;
      busy_count_reg <= busy_count_next;
    end
  end

  assign zero_1 = ZERO_REG && (read_reg_1 == '0);
  assign zero_2 = ZERO_REG && (read_reg_2 == '0);

  assign read_data_1 = zero_1 ? '0 : mem_word[read_reg_1];
  assign read_data_2 = zero_2 ? '0 : mem_word[read_reg_2];
  assign read_busy_1 = !zero_1 && busy_reg[read_reg_1];
  assign read_busy_2 = !zero_2 && busy_reg[read_reg_2];

  assign busy_count = busy_count_reg;
  assign any_busy   = (busy_count_reg != '0);
endmodule

// File: tb/tb_mips_regfile_sb.sv
// Bench for mips_regfile_sb: one instance with ZERO_REG=0 and one with ZERO_REG=1 share
// stimulus; both are compared against an array-based model of the register-file rules.
module tb_mips_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int NB = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b1;
  logic          rst_n = 1'b0;
  logic [AW-1:0] read_reg_1 = '0, read_reg_2 = '0, write_reg = '0, reserve_reg = '0;
  logic [DW-1:0] write_data = '0;
  logic [NB-1:0] write_be = '0;
  logic          signal_reg_write = 1'b0, signal_reserve = 1'b0;

  // Index 0: ZERO_REG=0 instance, index 1: ZERO_REG=1 instance.
  logic [DW-1:0] rd1 [2];
  logic [DW-1:0] rd2 [2];
  logic          rb1 [2];
  logic          rb2 [2];
  logic [AW:0]   bc  [2];
  logic          ab  [2];

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] m_data [2][DEPTH];
  bit            m_busy [2][DEPTH];

  always #20 clk = ~clk;

  mips_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
    .read_data_1(rd1[0]), .read_data_2(rd2[0]),
    .read_busy_1(rb1[0]), .read_busy_2(rb2[0]),
    .write_reg(write_reg), .write_data(write_data), .write_be(write_be),
    .signal_reg_write(signal_reg_write),
    .reserve_reg(reserve_reg), .signal_reserve(signal_reserve),
    .busy_count(bc[0]), .any_busy(ab[0])
  );

  mips_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
    .read_data_1(rd1[1]), .read_data_2(rd2[1]),
    .read_busy_1(rb1[1]), .read_busy_2(rb2[1]),
    .write_reg(write_reg), .write_data(write_data), .write_be(write_be),
    .signal_reg_write(signal_reg_write),
    .reserve_reg(reserve_reg), .signal_reserve(signal_reserve),
    .busy_count(bc[1]), .any_busy(ab[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int z = 0; z < 2; z++)
      for (int r = 0; r < DEPTH; r++) begin
        m_data[z][r] = '0;
        m_busy[z][r] = 1'b0;
      end
  endtask

  task automatic model_edge(input logic we, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                            input logic [NB-1:0] be, input logic rs, input logic [AW-1:0] rr);
    logic [DW-1:0] mask;
    mask = '0;
    for (int b = 0; b < NB; b++) if (be[b]) mask[b*8 +: 8] = 8'hFF;
    for (int z = 0; z < 2; z++) begin
      if (we && !(z == 1 && wr == 0)) begin
        m_data[z][wr] = (m_data[z][wr] & ~mask) | (wd & mask);
        m_busy[z][wr] = 1'b0;
      end
      if (rs && !(z == 1 && rr == 0)) m_busy[z][rr] = 1'b1;
    end
  endtask

  function automatic int model_count(input int z);
    int n = 0;
    for (int r = 0; r < DEPTH; r++) n += int'(m_busy[z][r]);
    return n;
  endfunction

  // Sweeps every address on both ports of both instances against the model.
  task automatic check_all(input string tag);
    logic [DW-1:0] e1, e2;
    int a2;
    for (int a = 0; a < DEPTH; a++) begin
      a2 = DEPTH - 1 - a;
      read_reg_1 = AW'(a);
      read_reg_2 = AW'(a2);
      #1;
      for (int z = 0; z < 2; z++) begin
        e1 = (z == 1 && a == 0) ? '0 : m_data[z][a];
        e2 = (z == 1 && a2 == 0) ? '0 : m_data[z][a2];
        chk($sformatf("%s_d1_z%0d_r%0d", tag, z, a), rd1[z], e1);
        chk($sformatf("%s_d2_z%0d_r%0d", tag, z, a2), rd2[z], e2);
        chk($sformatf("%s_b1_z%0d_r%0d", tag, z, a), rb1[z], (z == 1 && a == 0) ? 1'b0 : m_busy[z][a]);
        chk($sformatf("%s_b2_z%0d_r%0d", tag, z, a2), rb2[z], (z == 1 && a2 == 0) ? 1'b0 : m_busy[z][a2]);
      end
    end
    for (int z = 0; z < 2; z++) begin
      chk($sformatf("%s_cnt_z%0d", tag, z), bc[z], model_count(z));
      chk($sformatf("%s_any_z%0d", tag, z), ab[z], model_count(z) != 0);
    end
  endtask

  task automatic cycle(input logic we, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                       input logic [NB-1:0] be, input logic rs, input logic [AW-1:0] rr);
    @(posedge clk);
    #1;
    signal_reg_write = we; write_reg = wr; write_data = wd; write_be = be;
    signal_reserve = rs; reserve_reg = rr;
    @(negedge clk);
    if (rst_n) model_edge(we, wr, wd, be, rs, rr);
    #1;
    signal_reg_write = 1'b0;
    signal_reserve = 1'b0;
  endtask

  task automatic peek(input logic [AW-1:0] a);
    read_reg_1 = a;
    read_reg_2 = a;
    #1;
  endtask

  initial begin
    model_reset();
    #3;
    check_all("por");
    @(posedge clk); #2; rst_n = 1'b1;

    // Write then read in the same cycle, and the hardwired zero register
    cycle(1, 3'd5, 32'hDEADBEEF, 4'hF, 0, 3'd0);
    peek(3'd5);
    chk("wr_r5", rd1[1], 32'hDEADBEEF);
    cycle(1, 3'd0, 32'h12345678, 4'hF, 0, 3'd0);
    peek(3'd0);
    chk("wr_r0_zero", rd1[1], 32'h0);
    chk("wr_r0_plain", rd2[0], 32'h12345678);
    check_all("wr");

    // Byte enables
    cycle(1, 3'd2, 32'h11223344, 4'hF, 0, 3'd0);
    cycle(1, 3'd2, 32'hAABBCCDD, 4'b0101, 0, 3'd0);
    peek(3'd2);
    chk("be_r2", rd2[1], 32'h11BB33DD);
    check_all("be");

    // Scoreboard basics
    cycle(0, 3'd0, 32'h0, 4'h0, 1, 3'd3);
    cycle(0, 3'd0, 32'h0, 4'h0, 1, 3'd4);
    peek(3'd3);
    chk("sb_cnt2", bc[1], 2);
    chk("sb_busy3", rb1[1], 1'b1);
    cycle(1, 3'd3, 32'h33, 4'hF, 0, 3'd0);
    peek(3'd3);
    chk("sb_cnt1", bc[1], 1);
    chk("sb_free3", rb1[1], 1'b0);
    cycle(0, 3'd0, 32'h0, 4'h0, 1, 3'd0);
    peek(3'd0);
    chk("sb_r0_cnt", bc[1], 1);
    chk("sb_r0_busy", rb1[1], 1'b0);
    chk("sb_r0_plain_cnt", bc[0], 2);
    check_all("sb");

    // Simultaneous write and reserve
    cycle(0, 3'd0, 32'h0, 4'h0, 1, 3'd6);
    cycle(1, 3'd6, 32'h66666666, 4'hF, 1, 3'd6);
    peek(3'd6);
    chk("sim_same_data", rd1[1], 32'h66666666);
    chk("sim_same_busy", rb1[1], 1'b1);
    chk("sim_same_cnt", bc[1], 2);
    cycle(1, 3'd6, 32'h0A0B0C0D, 4'hF, 1, 3'd7);
    peek(3'd7);
    chk("sim_diff_cnt", bc[1], 2);
    chk("sim_diff_busy7", rb1[1], 1'b1);
    check_all("sim");

    // Write with no byte lanes still retires the reservation
    cycle(1, 3'd7, 32'hFFFFFFFF, 4'h0, 0, 3'd0);
    peek(3'd7);
    chk("be0_data", rd1[1], 32'h0);
    chk("be0_busy", rb1[1], 1'b0);
    check_all("be0");

    // Saturation
    for (int r = 1; r < DEPTH; r++) cycle(0, 3'd0, 32'h0, 4'h0, 1, AW'(r));
    chk("sat_cnt7", bc[1], 7);
    cycle(0, 3'd0, 32'h0, 4'h0, 1, 3'd1);
    chk("sat_rereserve", bc[1], 7);
    chk("sat_plain_cnt8", bc[0], 8);
    chk("sat_plain_any", ab[0], 1'b1);
    check_all("sat");

    // Asynchronous reset in the middle of a cycle, then held across an edge
    for (int r = 0; r < DEPTH; r++) cycle(1, AW'(r), 32'hFFFFFFFF, 4'hF, 1, AW'((r + 3) % DEPTH));
    @(posedge clk); #5;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_cnt", bc[1], 0);
    chk("rst_any", ab[0], 1'b0);
    check_all("rst");
    cycle(1, 3'd5, 32'h55555555, 4'hF, 1, 3'd5);
    check_all("rst_hold");
    @(posedge clk); #2; rst_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), $urandom,
            NB'($urandom_range(0, (1 << NB) - 1)),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)));
      check_all($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips_regfile_sb.md
# mips_regfile_sb

Parametrised MIPS general-purpose register file with byte-enabled writes, hardwired zero register, asynchronous clear and a per-register busy scoreboard for multi-cycle (load) results. It sits in the decode stage of the miniMIPS datapath: two combinational read ports feed the ALU operand muxes, one write port takes the writeback result, and the scoreboard lets control stall on operands whose producer has not yet written back.

## Interface
- DATA_W, 32, register width in bits; multiple of 8
- ADDR_W, 3, register address width; depth = 2^ADDR_W
- ZERO_REG, 1, 1 = register 0 reads as 0, is never written and is never busy; 0 = register 0 is ordinary
- clk  input  1  clock; all state updates on the falling edge
- rst_n  input  1  asynchronous active-low reset
- read_reg_1  input  ADDR_W  read port 1 address
- read_reg_2  input  ADDR_W  read port 2 address
- read_data_1  output  DATA_W  contents of read_reg_1, combinational
- read_data_2  output  DATA_W  contents of read_reg_2, combinational
- read_busy_1  output  1  busy bit of read_reg_1, combinational
- read_busy_2  output  1  busy bit of read_reg_2, combinational
- write_reg  input  ADDR_W  write address
- write_data  input  DATA_W  write data
- write_be  input  DATA_W/8  byte enables; bit i covers write_data[8i+7:8i]
- signal_reg_write  input  1  write strobe
- reserve_reg  input  ADDR_W  destination being reserved by an issuing multi-cycle instruction
- signal_reserve  input  1  reserve strobe
- busy_count  output  ADDR_W+1  number of registers currently busy
- any_busy  output  1  busy_count != 0

## Operation
- Storage: 2^ADDR_W x DATA_W array plus 2^ADDR_W busy bits, busy_count register.
- Reads: read_data_n = array[read_reg_n], read_busy_n = busy[read_reg_n]; when ZERO_REG=1 and address is 0, data forced 0 and busy forced 0.
- Write (falling edge, signal_reg_write=1, write_reg not blocked): each byte lane with write_be[i]=1 updated; lanes with write_be[i]=0 retain old value. write_be all zero: data unchanged, busy still cleared.
- Blocked write: ZERO_REG=1 and write_reg=0 -> no data change, no busy change.
- Write clears busy[write_reg].
- Reserve (falling edge, signal_reserve=1, reserve_reg not blocked by ZERO_REG rule): sets busy[reserve_reg].
- Same edge, write and reserve to same register: data written, busy ends 1 (reserve wins; new producer outstanding).
- Same edge, different registers: both take effect independently.
- Reserve of an already-busy register: busy stays 1, busy_count unchanged.
- Write to a non-busy register: normal write, busy_count unchanged.
- busy_count tracks population of busy bits exactly: +1 on 0->1 transition, -1 on 1->0, net of both events in one edge; range 0..2^ADDR_W, never wraps.
- Reset (rst_n=0, any time, independent of clk): all registers 0, all busy 0, busy_count 0; held while rst_n=0; writes and reserves ignored. Reset mid-operation discards outstanding reservations.

## Timing
- Read ports: zero latency, purely combinational from address and stored state.
- Write/reserve take effect at the falling edge of clk; new data and busy bits visible on read ports immediately after that edge, i.e. within the second half of the same cycle (write-then-read in one cycle, MIPS convention). No separate bypass path.
- busy_count and any_busy update at the same falling edge as busy bits.
- Reset outputs: read_data_n = 0, read_busy_n = 0, busy_count = 0, any_busy = 0, asserted asynchronously on rst_n falling; first update allowed on the first falling clk edge after rst_n rises.

## Test plan
- Reset: fill regs with 0xFFFFFFFF, reserve 3 regs, pulse rst_n low mid-cycle -> all read_data 0, busy 0, busy_count 0 before next clk edge.
- Write/read: write 0xDEADBEEF to r5, be=4'b1111, read r5 on port 1 in same cycle after falling edge -> 0xDEADBEEF; write r0 0x12345678 -> r0 reads 0.
- Byte enables: r2=0x11223344, write 0xAABBCCDD be=4'b0101 -> r2=0x11BB33DD.
- Scoreboard: reserve r3, r4 -> busy_count 2, read_busy on r3 = 1; write r3 -> busy_count 1, r3 not busy; reserve r0 -> busy_count unchanged.
- Simultaneous: r6 busy, same edge write r6 and reserve r6 -> data updated, busy_6=1, busy_count unchanged; write r6 + reserve r7 -> count unchanged, r7 busy.
- Saturation: reserve all 7 non-zero regs (ADDR_W=3, ZERO_REG=1) -> busy_count 7, re-reserve r1 -> still 7; ZERO_REG=0 build reserves 8 -> busy_count 8, no wrap.
